// File: rtl/alu_result_select.sv
// alu_result_select: picks one of M N-bit candidate results by channel index
// and buffers it in a two-entry skid stage (output register + skid register)
// with a valid/ready handshake on both sides.
// Index values >= M yield a zero result tagged with out_err.
// Optional feature macro ALU_RESULT_ZERO_FLAG_EN: when defined, each stored
// entry carries a zero flag (result == 0). When undefined, out_zero is tied
// low and no zero-detect logic is built.
module alu_result_select #(
  parameter  int N  = 4,
  parameter  int M  = 10,
  localparam int SW = $clog2(M)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [M-1:0][N-1:0] in_data,
  input  logic [SW-1:0]       in_sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [N-1:0]        out_data,
  output logic                out_zero,
  output logic                out_err,
  output logic                out_valid,
  input  logic                out_ready
);

  // The channel count widened by one bit so that it can be compared against
  // in_sel even when M is a power of two.
  localparam logic [SW:0] M_LIM = (SW+1)'(M);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e      state_q;
  logic        out_valid_q;
  logic        in_ready_q;

  logic [N-1:0] or_data_q, or_data_d;
  logic         or_err_q,  or_err_d;
  logic [N-1:0] sr_data_q, sr_data_d;
  logic         sr_err_q,  sr_err_d;

  logic [N-1:0] cap_data;
  logic         cap_err;

  logic accept;
  logic pop;
  logic load_or;
  logic load_sr;
  logic shift_sr;

  // Select the candidate named by in_sel. An out-of-range index matches no
  // channel, so the default of zero is what gets captured.
  // NOTE: every signal written in always_comb gets a default first; a path that leaves it unassigned would infer a latch.
  always_comb begin
    cap_data = '0;
    for (int i = 0; i < M; i++) begin
      if (in_sel == SW'(i)) cap_data = in_data[i];
    end
  end

  assign cap_err = ({1'b0, in_sel} >= M_LIM);

  // Handshake events and the datapath moves they cause in each state.
  assign accept   = in_valid && in_ready_q;
  assign pop      = out_valid_q && out_ready;
  assign load_or  = accept && ((state_q == ST_EMPTY) || ((state_q == ST_ONE) && pop));
  assign load_sr  = accept && (state_q == ST_ONE) && !pop;
  assign shift_sr = pop && (state_q == ST_TWO);

  // Control FSM: occupancy state with registered out_valid / in_ready.
  // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_q     <= ST_ONE;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && !pop) begin
            state_q     <= ST_TWO;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b0;
          end else if (pop && !accept) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state_q     <= ST_ONE;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  // Next contents of the output and skid registers; everything holds unless
  // the FSM moves an entry in.
  always_comb begin
    or_data_d = or_data_q;
    or_err_d  = or_err_q;
    sr_data_d = sr_data_q;
    sr_err_d  = sr_err_q;
    if (load_or) begin
      or_data_d = cap_data;
      or_err_d  = cap_err;
    end else if (shift_sr) begin
      or_data_d = sr_data_q;
      or_err_d  = sr_err_q;
    end
    if (load_sr) begin
      sr_data_d = cap_data;
      sr_err_d  = cap_err;
    end
  end

  // Entry storage for the output and skid registers.
  // NOTE: data registers are reset too, because the outputs must read zero after reset and stale skid contents must never resurface.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      or_data_q <= '0;
      or_err_q  <= 1'b0;
      sr_data_q <= '0;
      sr_err_q  <= 1'b0;
    end else begin
      or_data_q <= or_data_d;
      or_err_q  <= or_err_d;
      sr_data_q <= sr_data_d;
      sr_err_q  <= sr_err_d;
    end
  end

`ifdef ALU_RESULT_ZERO_FLAG_EN
  logic cap_zero;
  logic or_zero_q, or_zero_d;
  logic sr_zero_q, sr_zero_d;

  // Error entries carry zero data, so they also raise the zero flag.
  assign cap_zero = (cap_data == '0);

  // Zero flag follows its entry through the same moves as the data.
  always_comb begin
    or_zero_d = or_zero_q;
    sr_zero_d = sr_zero_q;
    if (load_or)       or_zero_d = cap_zero;
    else if (shift_sr) or_zero_d = sr_zero_q;
    if (load_sr)       sr_zero_d = cap_zero;
  end

  // Zero flag storage alongside each entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      or_zero_q <= 1'b0;
      sr_zero_q <= 1'b0;
    end else begin
      or_zero_q <= or_zero_d;
      sr_zero_q <= sr_zero_d;
    end
  end

  assign out_zero = or_zero_q;
`else
  assign out_zero = 1'b0;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = or_data_q;
  assign out_err   = or_err_q;

endmodule

// File: doc/alu_result_select.md
ALU_RESULT_SELECT -- requirements
Module: alu_result_select

Interface
REQ-001 Parameter N, default 4, data width of every input channel and of out_data.
REQ-002 Parameter M, default 10, number of input channels (legal range 2..16).
REQ-003 Derived localparam SW = $clog2(M), select width.
REQ-004 Clock and reset SHALL be one clock and a synchronous, active-low reset: clk (input, 1, rising-edge clock) and rst_n (input, 1, synchronous active-low reset).
REQ-005 in_data  input  M*N (packed [M-1:0][N-1:0])  candidate results, channel i at [i].
REQ-006 in_sel  input  SW  channel index to capture.
REQ-007 in_valid  input  1  upstream offers in_data/in_sel.
REQ-008 in_ready  output  1  block can accept; driven only from registers.
REQ-009 out_data  output  N  selected result.
REQ-010 out_zero  output  1  out_data == 0 flag (see Configuration).
REQ-011 out_err  output  1  captured in_sel was >= M.
REQ-012 out_valid  output  1  out_data/out_zero/out_err are valid.
REQ-013 out_ready  input  1  downstream consumes.

Function
REQ-014 Accept occurs on a rising edge with in_valid && in_ready; pop occurs on a rising edge with out_valid && out_ready.
REQ-015 Selection: sel < M -> captured data = in_data[sel], err = 0; sel >= M -> captured data = 0, err = 1.
REQ-016 Storage SHALL be two entries: output register (OR) and skid register (SR); state machine EMPTY / ONE / TWO.
REQ-017 EMPTY: out_valid=0, in_ready=1; accept -> load OR, go ONE.
REQ-018 ONE: out_valid=1, in_ready=1; accept and no pop -> load SR, go TWO; pop and no accept -> EMPTY; accept and pop same edge -> load OR with new item, stay ONE.
REQ-019 TWO: out_valid=1, in_ready=0; pop -> OR <= SR, go ONE; no pop -> hold everything.
REQ-020 Latency: item accepted at edge k SHALL appear on out_* with out_valid=1 immediately after edge k when state was EMPTY.
REQ-021 Ordering SHALL be strict FIFO; no item dropped or duplicated.
REQ-022 While out_valid=1 and out_ready=0, out_data/out_zero/out_err SHALL be stable.
REQ-023 Sustained in_valid=1, out_ready=1 SHALL give one item per cycle throughput.
REQ-024 in_sel and in_data are sampled only on accept; changes at other times have no effect.
REQ-025 Widths: no arithmetic; out_data is exactly N bits, zero-extended nowhere.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force state EMPTY, out_valid=0, in_ready=1, out_data=0, out_zero=0, out_err=0, SR cleared.
REQ-027 Reset mid-operation (ONE or TWO) SHALL discard all stored items; reset has priority over accept and pop on the same edge.

Configuration
REQ-028 Macro ALU_RESULT_ZERO_FLAG_EN: defined -> out_zero captured per entry as (captured data == 0), including 1 for err items; undefined -> out_zero tied 0 and no zero-detect logic exists.

Verification (N=4, M=10)
REQ-029 Reset then in_sel=3, in_data[3]=4'hA, in_valid=1 one cycle, out_ready=1 -> next cycle out_valid=1, out_data=4'hA, out_err=0, out_zero=0; following cycle out_valid=0.
REQ-030 in_sel=12 (>=M) accepted -> out_data=0, out_err=1, out_zero=1 with macro, 0 without.
REQ-031 out_ready=0, accept items sel=1 (5) then sel=2 (6) -> in_ready=0 after second accept, out_data=5 stable; raise out_ready -> 5 then 6 in order, in_ready returns 1.
REQ-032 in_valid=1, out_ready=1 for 10 cycles with sel=0..9, in_data[i]=i -> out_data 0..9 on consecutive cycles, no bubbles.
REQ-033 State TWO, assert rst_n=0 one edge with in_valid=1 -> out_valid=0, in_ready=1, all outputs 0, no item later emitted.
REQ-034 in_data[0]=0 accepted with macro defined -> out_zero=1, out_err=0.
